// File: rtl/vga_pkg.sv
// Shared types and default 800x600@60 timings for the VGA axis timing generator.
package vga_pkg;

   localparam int VGA_CNT_W = 11;

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FRONT  = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BACK   = 2'd3
   } phase_t;

   typedef struct packed {
      logic [VGA_CNT_W-1:0] active;
      logic [VGA_CNT_W-1:0] front;
      logic [VGA_CNT_W-1:0] sync;
      logic [VGA_CNT_W-1:0] back;
   } timing_t;

   // 800x600@60 with a 40 MHz pixel clock; vertical units are lines.
   localparam timing_t H_800X600 = '{active: 11'd800, front: 11'd40, sync: 11'd128, back: 11'd88};
   localparam timing_t V_800X600 = '{active: 11'd600, front: 11'd1, sync: 11'd4, back: 11'd23};

   function automatic logic [VGA_CNT_W+1:0] timing_total(input timing_t t);
      return {2'b00, t.active} + {2'b00, t.front} + {2'b00, t.sync} + {2'b00, t.back};
   endfunction

endpackage

// File: rtl/vga_timing_shadow.sv
// Live and pending timing registers for vga_axis_timer; new timing only goes live at wrap.
// Used only when VGA_AXIS_LOAD_EN is defined.
module vga_timing_shadow #(
   parameter int CNT_W  = 11,
   parameter int ACTIVE = 600,
   parameter int FRONT  = 1,
   parameter int SYNC   = 4,
   parameter int BACK   = 23
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tc,
   input  logic               ld_valid,
   input  logic [4*CNT_W-1:0] ld_timing,
   output logic [4*CNT_W-1:0] live,
   output logic               ld_pending,
   output logic               ld_err
);

   localparam logic [4*CNT_W-1:0] RESET_TIMING =
      {CNT_W'(ACTIVE), CNT_W'(FRONT), CNT_W'(SYNC), CNT_W'(BACK)};

   logic [4*CNT_W-1:0] pending_q;
   logic               ld_ok;

   // A period with no visible area is meaningless, so such loads are dropped.
   assign ld_ok = ld_valid && (ld_timing[4*CNT_W-1 -: CNT_W] != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         live       <= RESET_TIMING;
         pending_q  <= RESET_TIMING;
         ld_pending <= 1'b0;
         ld_err     <= 1'b0;
      end else begin
         ld_err <= ld_valid && !ld_ok;
         if (tc) begin
            if (ld_ok) begin
               live <= ld_timing;
            end else if (ld_pending) begin
               live <= pending_q;
            end
            ld_pending <= 1'b0;
         end else if (ld_ok) begin
            pending_q  <= ld_timing;
            ld_pending <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/vga_axis_timer.sv
// One VGA timing axis (horizontal or vertical) with phase FSM and terminal-count cascade.
// Define VGA_AXIS_LOAD_EN to add runtime timing reload through the ld_* ports.
module vga_axis_timer
   import vga_pkg::*;
#(
   parameter int CNT_W    = 11,
   parameter int ACTIVE   = 600,
   parameter int FRONT    = 1,
   parameter int SYNC     = 4,
   parameter int BACK     = 23,
   parameter bit SYNC_POL = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   output logic [CNT_W-1:0]   cnt,
   output logic [CNT_W-1:0]   pos,
   output logic               sync,
   output logic               blank,
   output logic               active,
   output logic [1:0]         phase,
   output logic               tc
`ifdef VGA_AXIS_LOAD_EN
   ,
   input  logic               ld_valid,
   input  logic [4*CNT_W-1:0] ld_timing,
   output logic               ld_pending,
   output logic               ld_err
`endif
);

   localparam int P_TOTAL = ACTIVE + FRONT + SYNC + BACK;
   localparam logic [CNT_W+1:0] ONE_W = 1;

   if (ACTIVE < 1) begin : g_bad_active
      $error("vga_axis_timer: ACTIVE must be at least 1");
   end
   if (P_TOTAL > (1 << CNT_W)) begin : g_bad_total
      $error("vga_axis_timer: period does not fit in CNT_W bits");
   end

   logic [CNT_W-1:0] t_active, t_front, t_sync, t_back;
   logic [CNT_W+1:0] b_front, b_sync, b_back, total;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W+1:0] cnt_next_w;
   phase_t           phase_q, phase_next;

`ifdef VGA_AXIS_LOAD_EN
   logic [4*CNT_W-1:0] live;

   vga_timing_shadow #(
      .CNT_W (CNT_W),
      .ACTIVE(ACTIVE),
      .FRONT (FRONT),
      .SYNC  (SYNC),
      .BACK  (BACK)
   ) u_shadow (
      .clk       (clk),
      .rst_n     (rst_n),
      .tc        (tc),
      .ld_valid  (ld_valid),
      .ld_timing (ld_timing),
      .live      (live),
      .ld_pending(ld_pending),
      .ld_err    (ld_err)
   );

   assign t_active = live[4*CNT_W-1 -: CNT_W];
   assign t_front  = live[3*CNT_W-1 -: CNT_W];
   assign t_sync   = live[2*CNT_W-1 -: CNT_W];
   assign t_back   = live[CNT_W-1 -: CNT_W];
`else
   assign t_active = CNT_W'(ACTIVE);
   assign t_front  = CNT_W'(FRONT);
   assign t_sync   = CNT_W'(SYNC);
   assign t_back   = CNT_W'(BACK);
`endif

   // Boundaries carry two extra bits so a full-width period cannot overflow.
   assign b_front = {2'b00, t_active};
   assign b_sync  = b_front + {2'b00, t_front};
   assign b_back  = b_sync + {2'b00, t_sync};
   assign total   = b_back + {2'b00, t_back};

   assign tc     = enable && ({2'b00, cnt} == (total - ONE_W));
   assign phase  = phase_q;
   assign active = ~blank;

   // Next phase is derived from the next count so registered outputs line up with cnt;
   // zero-length phases fall through within the same transition.
   always_comb begin
      cnt_next   = tc ? '0 : cnt + CNT_W'(1);
      cnt_next_w = {2'b00, cnt_next};
      phase_next = phase_q;
      if (tc) begin
         phase_next = PH_ACTIVE;
      end else begin
         case (phase_q)
            PH_ACTIVE: begin
               if (cnt_next_w == b_front) begin
                  phase_next = (t_front != '0) ? PH_FRONT :
                               (t_sync  != '0) ? PH_SYNC  : PH_BACK;
               end
            end
            PH_FRONT: begin
               if (cnt_next_w == b_sync) begin
                  phase_next = (t_sync != '0) ? PH_SYNC : PH_BACK;
               end
            end
            PH_SYNC: begin
               if (cnt_next_w == b_back) begin
                  phase_next = PH_BACK;
               end
            end
            default: phase_next = PH_BACK;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt     <= '0;
         pos     <= '0;
         phase_q <= PH_ACTIVE;
         sync    <= ~SYNC_POL;
         blank   <= 1'b0;
      end else if (enable) begin
         cnt     <= cnt_next;
         phase_q <= phase_next;
         sync    <= (phase_next == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
         blank   <= (phase_next != PH_ACTIVE);
         if (phase_next == PH_ACTIVE) begin
            pos <= cnt_next;
         end
      end
   end

endmodule

// File: tb/tb_vga_axis_timer.sv
// Self-checking bench for vga_axis_timer: free-run, enable gating, H->V cascade,
// zero-length front porch, runtime reload (VGA_AXIS_LOAD_EN) and reset mid-period.
module tb_vga_axis_timer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en_main;
   logic        ld_valid_d;
   logic [15:0] ld_timing_d;

   logic [3:0] a_cnt, a_pos, h_cnt, h_pos, v_cnt, v_pos, z_cnt, z_pos;
   logic       a_sync, a_blank, a_active, a_tc;
   logic       h_sync, h_blank, h_active, h_tc;
   logic       v_sync, v_blank, v_active, v_tc;
   logic       z_sync, z_blank, z_active, z_tc;
   logic [1:0] a_phase, h_phase, v_phase, z_phase;
`ifdef VGA_AXIS_LOAD_EN
   logic       a_pend, a_err, h_pend, h_err, v_pend, v_err, z_pend, z_err;
`endif

   always #5 clk = ~clk;

   vga_axis_timer #(.CNT_W(4), .ACTIVE(4), .FRONT(1), .SYNC(2), .BACK(1), .SYNC_POL(1'b1)) u_main (
      .clk(clk), .rst_n(rst_n), .enable(en_main), .cnt(a_cnt), .pos(a_pos), .sync(a_sync),
      .blank(a_blank), .active(a_active), .phase(a_phase), .tc(a_tc)
`ifdef VGA_AXIS_LOAD_EN
      , .ld_valid(ld_valid_d), .ld_timing(ld_timing_d), .ld_pending(a_pend), .ld_err(a_err)
`endif
   );

   vga_axis_timer #(.CNT_W(4), .ACTIVE(4), .FRONT(1), .SYNC(2), .BACK(1), .SYNC_POL(1'b1)) u_h (
      .clk(clk), .rst_n(rst_n), .enable(1'b1), .cnt(h_cnt), .pos(h_pos), .sync(h_sync),
      .blank(h_blank), .active(h_active), .phase(h_phase), .tc(h_tc)
`ifdef VGA_AXIS_LOAD_EN
      , .ld_valid(1'b0), .ld_timing(16'h0000), .ld_pending(h_pend), .ld_err(h_err)
`endif
   );

   vga_axis_timer #(.CNT_W(4), .ACTIVE(4), .FRONT(1), .SYNC(2), .BACK(1), .SYNC_POL(1'b1)) u_v (
      .clk(clk), .rst_n(rst_n), .enable(h_tc), .cnt(v_cnt), .pos(v_pos), .sync(v_sync),
      .blank(v_blank), .active(v_active), .phase(v_phase), .tc(v_tc)
`ifdef VGA_AXIS_LOAD_EN
      , .ld_valid(1'b0), .ld_timing(16'h0000), .ld_pending(v_pend), .ld_err(v_err)
`endif
   );

   vga_axis_timer #(.CNT_W(4), .ACTIVE(4), .FRONT(0), .SYNC(2), .BACK(1), .SYNC_POL(1'b0)) u_zf (
      .clk(clk), .rst_n(rst_n), .enable(1'b1), .cnt(z_cnt), .pos(z_pos), .sync(z_sync),
      .blank(z_blank), .active(z_active), .phase(z_phase), .tc(z_tc)
`ifdef VGA_AXIS_LOAD_EN
      , .ld_valid(1'b0), .ld_timing(16'h0000), .ld_pending(z_pend), .ld_err(z_err)
`endif
   );

   typedef struct {
      string tag;
      int    cnt, pos, blank, sync, phase, tc, pend, err;
      int    h_cnt, h_tc, v_cnt, v_tc, z_cnt, z_sync, z_phase, z_tc;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   // Reference model state: main axis position/timing/load and a free clock count for the others.
   int mc, m_pos, kc;
   int t_act, t_fr, t_sy, t_bk;
   int p_act, p_fr, p_sy, p_bk;
   bit m_pend, m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic resetModel();
      mc = 0; m_pos = 0; kc = 0;
      t_act = 4; t_fr = 1; t_sy = 2; t_bk = 1;
      p_act = 4; p_fr = 1; p_sy = 2; p_bk = 1;
      m_pend = 1'b0; m_err = 1'b0;
   endtask

   function automatic bit modelSync();
      return (mc >= t_act + t_fr) && (mc < t_act + t_fr + t_sy);
   endfunction

   // Called on a falling edge: drive inputs, queue what the DUTs must show now, advance the model.
   task automatic applyStimulus(input logic en, input string tag);
      exp_t e;
      int   total, z, ta;
      bit   ok;
      en_main = en;
      total   = t_act + t_fr + t_sy + t_bk;
      z       = kc % 7;
      e.tag   = tag;
      e.cnt   = mc;
      e.pos   = m_pos;
      e.blank = int'(mc >= t_act);
      e.sync  = int'(modelSync());
      e.phase = (mc < t_act) ? 0 : (mc < t_act + t_fr) ? 1 : (mc < t_act + t_fr + t_sy) ? 2 : 3;
      e.tc    = int'(en && (mc == total - 1));
      e.pend  = int'(m_pend);
      e.err   = int'(m_err);
      e.h_cnt = kc % 8;
      e.h_tc  = int'((kc % 8) == 7);
      e.v_cnt = (kc / 8) % 8;
      e.v_tc  = int'(((kc % 8) == 7) && (((kc / 8) % 8) == 7));
      e.z_cnt = z;
      e.z_sync  = int'(!(z >= 4 && z <= 5));
      e.z_phase = (z < 4) ? 0 : (z < 6) ? 2 : 3;
      e.z_tc    = int'(z == 6);
      sb.push_back(e);

      ta    = int'(ld_timing_d[15:12]);
      ok    = ld_valid_d && (ta != 0);
      m_err = ld_valid_d && !ok;
      if (e.tc != 0) begin
         if (ok) begin
            t_act = ta; t_fr = int'(ld_timing_d[11:8]);
            t_sy  = int'(ld_timing_d[7:4]); t_bk = int'(ld_timing_d[3:0]);
         end else if (m_pend) begin
            t_act = p_act; t_fr = p_fr; t_sy = p_sy; t_bk = p_bk;
         end
         m_pend = 1'b0;
         mc     = 0;
      end else begin
         if (ok) begin
            p_act = ta; p_fr = int'(ld_timing_d[11:8]);
            p_sy  = int'(ld_timing_d[7:4]); p_bk = int'(ld_timing_d[3:0]);
            m_pend = 1'b1;
         end
         if (en) mc++;
      end
      if (en && mc < t_act) m_pos = mc;
      kc++;
   endtask

   task automatic checkOutput();
      exp_t e;
      #1;
      e = sb.pop_front();
      chk({e.tag, ".cnt"},    a_cnt,    e.cnt);
      chk({e.tag, ".pos"},    a_pos,    e.pos);
      chk({e.tag, ".blank"},  a_blank,  e.blank);
      chk({e.tag, ".active"}, a_active, 1 - e.blank);
      chk({e.tag, ".sync"},   a_sync,   e.sync);
      chk({e.tag, ".phase"},  a_phase,  e.phase);
      chk({e.tag, ".tc"},     a_tc,     e.tc);
      chk({e.tag, ".h_cnt"},  h_cnt,    e.h_cnt);
      chk({e.tag, ".h_tc"},   h_tc,     e.h_tc);
      chk({e.tag, ".v_cnt"},  v_cnt,    e.v_cnt);
      chk({e.tag, ".v_tc"},   v_tc,     e.v_tc);
      chk({e.tag, ".z_cnt"},  z_cnt,    e.z_cnt);
      chk({e.tag, ".z_sync"}, z_sync,   e.z_sync);
      chk({e.tag, ".z_phase"}, z_phase, e.z_phase);
      chk({e.tag, ".z_tc"},   z_tc,     e.z_tc);
`ifdef VGA_AXIS_LOAD_EN
      chk({e.tag, ".ld_pending"}, a_pend, e.pend);
      chk({e.tag, ".ld_err"},     a_err,  e.err);
`endif
      @(negedge clk);
   endtask

   task automatic step(input logic en, input string tag);
      applyStimulus(en, tag);
      checkOutput();
   endtask

   task automatic checkReset(input string tag);
      chk({tag, ".cnt"},    a_cnt,    0);
      chk({tag, ".pos"},    a_pos,    0);
      chk({tag, ".blank"},  a_blank,  0);
      chk({tag, ".active"}, a_active, 1);
      chk({tag, ".sync"},   a_sync,   0);
      chk({tag, ".phase"},  a_phase,  0);
      chk({tag, ".tc"},     a_tc,     0);
      chk({tag, ".h_cnt"},  h_cnt,    0);
      chk({tag, ".v_cnt"},  v_cnt,    0);
      chk({tag, ".z_cnt"},  z_cnt,    0);
      chk({tag, ".z_sync"}, z_sync,   1);
`ifdef VGA_AXIS_LOAD_EN
      chk({tag, ".ld_pending"}, a_pend, 0);
      chk({tag, ".ld_err"},     a_err,  0);
`endif
   endtask

   initial begin
      rst_n       = 1'b0;
      en_main     = 1'b1;
      ld_valid_d  = 1'b0;
      ld_timing_d = 16'h0000;
      resetModel();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkReset("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) step(1'b1, "run");
      for (int i = 0; i < 8 && mc != 2; i++) step(1'b1, "run");

      step(1'b1, "gate");
      step(1'b0, "gate");
      step(1'b0, "gate");
      step(1'b1, "gate");
      step(1'b1, "gate");

      for (int i = 0; i < 8 && mc != 7; i++) step(1'b1, "pre_tc");
      step(1'b0, "tc_gated");
      step(1'b1, "wrap");

      for (int i = 0; i < 80 && kc < 72; i++) step(1'b1, "cascade");

`ifdef VGA_AXIS_LOAD_EN
      for (int i = 0; i < 8 && mc != 2; i++) step(1'b1, "pre_ld");
      ld_valid_d = 1'b1; ld_timing_d = 16'h6111;
      step(1'b1, "ld");
      ld_valid_d = 1'b0;
      for (int i = 0; i < 14; i++) step(1'b1, "ld_run");
      ld_valid_d = 1'b1; ld_timing_d = 16'h0111;
      step(1'b1, "ld_bad");
      ld_valid_d = 1'b0;
      for (int i = 0; i < 10; i++) step(1'b1, "ld_bad_run");
      for (int i = 0; i < 10 && mc != 1; i++) step(1'b1, "pre_ld2");
      ld_valid_d = 1'b1; ld_timing_d = 16'h5111;
      step(1'b1, "ld2");
      ld_valid_d = 1'b0;
`endif

      for (int i = 0; i < 12 && !modelSync(); i++) step(1'b1, "pre_rst");
      chk("pre_rst.sync", a_sync, 1);
`ifdef VGA_AXIS_LOAD_EN
      chk("pre_rst.ld_pending", a_pend, 1);
`endif
      rst_n = 1'b0;
      @(negedge clk);
      checkReset("mid_rst");
      rst_n = 1'b1;
      resetModel();
      for (int i = 0; i < 10; i++) step(1'b1, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/vga_axis_timer.md
Name: vga_axis_timer

Overview:
- Generic, parametrised VGA axis timing generator that supersedes the fixed horizontal and vertical counters. One instance produces one axis: horizontal (enable tied high) or vertical (enable driven by the horizontal instance's tc).
- Adds:
  - explicit phase FSM
  - configurable sync polarity
  - terminal-count cascade output
  - active-area coordinate
  - optional runtime timing reload, applied glitch-free at wrap

Parameters:
- CNT_W, 11, width of all counters and timing fields
- ACTIVE, 600, visible units per axis period (must be >= 1)
- FRONT, 1, front-porch length (0 allowed)
- SYNC, 4, sync-pulse length (0 allowed)
- BACK, 23, back-porch length (0 allowed)
- SYNC_POL, 1, asserted level of sync

Ports:
- clk, in, 1, clock
- rst_n, in, 1, synchronous active-low reset
- enable, in, 1, advance the count by one this cycle
- cnt, out, CNT_W, position in period, 0..TOTAL-1
- pos, out, CNT_W, active coordinate (= cnt while active, else held at last value)
- sync, out, 1, sync output, SYNC_POL-asserted
- blank, out, 1, high outside the active area
- active, out, 1, display-enable (= ~blank)
- phase, out, 2, current phase_t
- tc, out, 1, combinational: enable && cnt == TOTAL-1
- ld_valid, in, 1, load request (VGA_AXIS_LOAD_EN only)
- ld_timing, in, 4*CNT_W, packed timing_t {active, front, sync, back} (VGA_AXIS_LOAD_EN only)
- ld_pending, out, 1, a load is waiting for wrap (VGA_AXIS_LOAD_EN only)
- ld_err, out, 1, one-cycle pulse when a load is rejected (VGA_AXIS_LOAD_EN only)

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low on rst_n.
- Reset values:
  - cnt = 0, pos = 0, phase = ACTIVE
  - sync = ~SYNC_POL, blank = 0, active = 1
  - live timing = parameter values
  - ld_pending = 0, ld_err = 0
- Timing: TOTAL = active + front + sync + back, computed in CNT_W+2 bits. Instantiating with TOTAL > 2^CNT_W is a static error (assertion).
- Counter:
  - cnt advances only when enable = 1.
  - On tc, cnt wraps to 0; otherwise cnt increments.
  - enable = 0 holds every output except the ld_* signals.
- Alignment:
  - sync, blank, active, phase and pos are registered from next-state logic.
  - In the cycle where cnt = X, they describe position X. Zero cycles of skew relative to cnt.
- Phase FSM (phase_t): ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - Each phase lasts its length in enabled cycles.
  - A zero-length phase is skipped in the same transition, e.g. front = 0 goes ACTIVE -> SYNC directly.
  - Phase boundaries: FRONT begins at cnt = active; SYNC at active+front; BACK at active+front+sync.
- Outputs by phase:
  - sync = SYNC_POL exactly while phase == SYNC.
  - blank = 1 for every phase other than ACTIVE.
- tc is combinational for same-cycle cascade. tc = 0 when enable = 0.
- Timing reload (VGA_AXIS_LOAD_EN):
  - ld_valid captures ld_timing into a pending register and sets ld_pending.
  - Pending timing becomes live on the next tc, so cnt and phase restart at 0 / ACTIVE under the new timing. ld_pending then clears.
  - ld_valid while a load is already pending overwrites it; the last load wins.
  - ld_valid in the same cycle as tc applies the incoming value at that wrap, bypassing the pending register. ld_pending stays 0.
  - A load with active = 0 is rejected: ld_err pulses, and pending and live timing are unchanged.
  - Reset clears a pending load.

Optional Feature:
- Macro: VGA_AXIS_LOAD_EN.
- Defined: ld_* ports and the shadow/pending logic are present, and timing is runtime-reloadable as described above.
- Undefined:
  - ld_* ports are absent.
  - Live timing consists of parameter constants only.
  - TOTAL and all phase boundaries are elaboration-time constants.

Decomposition:
- vga_pkg gains:
  - typedef enum logic [1:0] phase_t {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK}
  - typedef struct packed timing_t {active, front, sync, back}, each field CNT_W bits
  - 800x600@60 default constants for both axes, e.g. H 800/40/128/88 and V 600/1/4/23
- Sub-module vga_timing_shadow holds:
  - live and pending timing registers
  - the validity check (active = 0 rejection)
  - the apply-on-tc rule
- vga_timing_shadow is instantiated only under VGA_AXIS_LOAD_EN.

Test Plan:
- Common bench setup: ACTIVE=4, FRONT=1, SYNC=2, BACK=1, enable always 1.
- Reset and free-run:
  - rst_n = 0 for 2 cycles -> cnt = 0, blank = 0, sync = 0.
  - Then cnt runs 0..7 and wraps.
  - blank = 1 at cnt 4..7; sync = 1 at cnt 5..6.
  - tc = 1 only at cnt = 7.
- Enable gating: enable toggled 1,0,0,1 starting at cnt = 3 -> cnt holds 3 for two cycles, then moves to 4 with blank = 1. tc is never asserted while enable = 0.
- Cascade: H instance tc drives V instance (same small timing) -> V cnt increments once per 8 clocks. V wraps 0 after 64 clocks; at that wrap both tc outputs are high in the same cycle.
- Zero-length phase: FRONT = 0, SYNC_POL = 0 -> sync = 0 at cnt 4..5, phase ACTIVE -> SYNC at cnt = 4, TOTAL = 7.
- Reload (VGA_AXIS_LOAD_EN):
  - ld_valid with {6,1,1,1} at cnt = 2 -> ld_pending = 1 until cnt 7 -> 0. Next period has TOTAL = 9 and blank at cnt 6..8.
  - A load with active = 0 -> ld_err pulses one cycle and the period is unchanged.
- Reset mid-operation: rst_n = 0 at cnt = 5 while sync is asserted and a load is pending -> next cycle cnt = 0, sync deasserted, ld_pending = 0, parameter timing restored.
